// File: rtl/regfile_sched.sv
// Two-port round-robin scheduler sharing a register file and an ALU; each grant
// runs READ -> EXEC -> WAIT -> (WB) -> IDLE. Optional macro SCHED_TIMEOUT_EN bounds WAIT.
module regfile_sched #(
  parameter int N = 19,
  parameter int M = 3
`ifdef SCHED_TIMEOUT_EN
  , parameter int TMO = 255
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [M:0]   src0_0,
  input  logic [M:0]   src1_0,
  input  logic [M:0]   dst_0,
  input  logic [M:0]   src0_1,
  input  logic [M:0]   src1_1,
  input  logic [M:0]   dst_1,
  input  logic         we_0,
  input  logic         we_1,
  output logic         ack0,
  output logic         ack1,
  output logic         busy,
  output logic [M:0]   rf_s0,
  output logic [M:0]   rf_s1,
  output logic         rf_rd0_en,
  output logic         rf_rd1_en,
  output logic [M:0]   rf_dest,
  output logic         rf_wr_en,
  output logic [N:0]   rf_wdata,
  output logic         alu_start,
  input  logic         alu_done,
  input  logic [N:0]   alu_result,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WAIT, WB} state_t;

  state_t     state;
  logic       last_grant;
  logic       gnt;
  logic [M:0] dst_q;
  logic       we_q;
  logic       grant_sel;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    grant_sel = req1;
    if (req0 && req1) grant_sel = ~last_grant;
  end

  assign busy = (state != IDLE);

`ifdef SCHED_TIMEOUT_EN
  logic [7:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  // NOTE: every register here, including the pulse outputs, is cleared by the
  // async reset and updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      dst_q      <= '0;
      we_q       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rf_s0      <= '0;
      rf_s1      <= '0;
      rf_rd0_en  <= 1'b0;
      rf_rd1_en  <= 1'b0;
      rf_dest    <= '0;
      rf_wr_en   <= 1'b0;
      rf_wdata   <= '0;
      alu_start  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      err        <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      alu_start <= 1'b0;
      rf_wr_en  <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      err       <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt        <= grant_sel;
            last_grant <= grant_sel;
            // The read selects double as the latched source fields.
            rf_s0      <= grant_sel ? src0_1 : src0_0;
            rf_s1      <= grant_sel ? src1_1 : src1_0;
            dst_q      <= grant_sel ? dst_1  : dst_0;
            we_q       <= grant_sel ? we_1   : we_0;
            rf_rd0_en  <= 1'b1;
            rf_rd1_en  <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          rf_rd0_en <= 1'b0;
          rf_rd1_en <= 1'b0;
          alu_start <= 1'b1;
          state     <= EXEC;
        end
        EXEC: begin
`ifdef SCHED_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (alu_done) begin
            rf_wdata <= alu_result;
            if (we_q) begin
              rf_dest  <= dst_q;
              rf_wr_en <= 1'b1;
              state    <= WB;
            end else begin
              state <= IDLE;
            end
            // Ack is raised together with the write so both appear in WB.
            ack0 <= ~gnt;
            ack1 <= gnt;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (tmo_cnt == 8'(TMO - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sched.sv
// Randomized bench for regfile_sched: a transaction-level model predicts the
// winner, the latched fields and the cycle each output should appear.
module tb_regfile_sched;

  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] d;
    logic       we;
  } fld_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [3:0]  src0_0, src1_0, dst_0, src0_1, src1_1, dst_1;
  logic        we_0, we_1;
  logic        ack0, ack1, busy;
  logic [3:0]  rf_s0, rf_s1, rf_dest;
  logic        rf_rd0_en, rf_rd1_en, rf_wr_en;
  logic [19:0] rf_wdata;
  logic        alu_start, alu_done;
  logic [19:0] alu_result;
  logic        err;

  int total = 0;
  int bad   = 0;
  bit m_last = 1'b1;
  bit grant_log[$];

  regfile_sched dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .src0_0(src0_0), .src1_0(src1_0), .dst_0(dst_0),
    .src0_1(src0_1), .src1_1(src1_1), .dst_1(dst_1),
    .we_0(we_0), .we_1(we_1), .ack0(ack0), .ack1(ack1), .busy(busy),
    .rf_s0(rf_s0), .rf_s1(rf_s1), .rf_rd0_en(rf_rd0_en), .rf_rd1_en(rf_rd1_en),
    .rf_dest(rf_dest), .rf_wr_en(rf_wr_en), .rf_wdata(rf_wdata),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_cycle(input string ph, input bit e_busy, input bit e_rd, input bit e_start,
                           input bit e_wr, input bit e_a0, input bit e_a1);
    check({ph, ".busy"},  32'(busy),      32'(e_busy));
    check({ph, ".rd0"},   32'(rf_rd0_en), 32'(e_rd));
    check({ph, ".rd1"},   32'(rf_rd1_en), 32'(e_rd));
    check({ph, ".start"}, 32'(alu_start), 32'(e_start));
    check({ph, ".wr"},    32'(rf_wr_en),  32'(e_wr));
    check({ph, ".ack0"},  32'(ack0),      32'(e_a0));
    check({ph, ".ack1"},  32'(ack1),      32'(e_a1));
    check({ph, ".err"},   32'(err),       32'd0);
  endtask

  task automatic drive_fields(input fld_t f0, input fld_t f1);
    src0_0 = f0.s0; src1_0 = f0.s1; dst_0 = f0.d; we_0 = f0.we;
    src0_1 = f1.s0; src1_1 = f1.s1; dst_1 = f1.d; we_1 = f1.we;
  endtask

  function automatic fld_t rnd_fld();
    return fld_t'(13'($urandom));
  endfunction

  // Change every requester input while busy; none of it may leak into the transaction.
  task automatic scramble(input bit with_done);
    req0 = 1'($urandom); req1 = 1'($urandom);
    drive_fields(rnd_fld(), rnd_fld());
    alu_result = 20'($urandom);
    alu_done   = with_done ? 1'($urandom) : 1'b0;
  endtask

  // Entered and left #1 after a posedge with the DUT in IDLE.
  task automatic run_txn(input bit r0, input bit r1, input fld_t f0, input fld_t f1,
                         input int dly, input logic [19:0] res, input bit abort);
    bit   win;
    fld_t f;
    win    = (r0 && r1) ? !m_last : r1;
    m_last = win;
    f      = win ? f1 : f0;
    grant_log.push_back(win);
    req0 = r0; req1 = r1;
    drive_fields(f0, f1);
    alu_done = 1'($urandom); alu_result = 20'($urandom);
    @(posedge clk); #1;
    chk_cycle("read", 1, 1, 0, 0, 0, 0);
    check("read.s0", 32'(rf_s0), 32'(f.s0));
    check("read.s1", 32'(rf_s1), 32'(f.s1));
    scramble(1'b1);
    @(posedge clk); #1;
    chk_cycle("exec", 1, 0, 1, 0, 0, 0);
    check("exec.s0", 32'(rf_s0), 32'(f.s0));
    check("exec.s1", 32'(rf_s1), 32'(f.s1));
    scramble(1'b1);
    @(posedge clk); #1;
    chk_cycle("wait", 1, 0, 0, 0, 0, 0);
    if (abort) begin
      rst_n = 1'b0;
      #1;
      chk_cycle("rst", 0, 0, 0, 0, 0, 0);
      check("rst.s0",    32'(rf_s0),    32'd0);
      check("rst.s1",    32'(rf_s1),    32'd0);
      check("rst.dest",  32'(rf_dest),  32'd0);
      check("rst.wdata", 32'(rf_wdata), 32'd0);
      m_last = 1'b1;
      req0 = 1'b0; req1 = 1'b0; alu_done = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk_cycle("after_rst", 0, 0, 0, 0, 0, 0);
      return;
    end
    for (int i = 0; i < dly; i++) begin
      scramble(1'b0);
      @(posedge clk); #1;
      chk_cycle("wait_n", 1, 0, 0, 0, 0, 0);
    end
    alu_done = 1'b1; alu_result = res;
    @(posedge clk); #1;
    alu_done = 1'b0;
    if (f.we) begin
      chk_cycle("wb", 1, 0, 0, 1, !win, win);
      check("wb.dest",  32'(rf_dest),  32'(f.d));
      check("wb.wdata", 32'(rf_wdata), 32'(res));
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk); #1;
      chk_cycle("post_wb", 0, 0, 0, 0, 0, 0);
      check("post_wb.wdata", 32'(rf_wdata), 32'(res));
    end else begin
      chk_cycle("done", 0, 0, 0, 0, !win, win);
      check("done.wdata", 32'(rf_wdata), 32'(res));
    end
  endtask

  task automatic idle_cycle();
    req0 = 1'b0; req1 = 1'b0; alu_done = 1'($urandom);
    @(posedge clk); #1;
    chk_cycle("idle", 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    fld_t fa, fb;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; alu_done = 1'b0; alu_result = '0;
    drive_fields('0, '0);
    #3;
    chk_cycle("reset", 0, 0, 0, 0, 0, 0);
    check("reset.s0",    32'(rf_s0),    32'd0);
    check("reset.dest",  32'(rf_dest),  32'd0);
    check("reset.wdata", 32'(rf_wdata), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    fa = '{s0: 4'd2, s1: 4'd5, d: 4'd7, we: 1'b1};
    run_txn(1'b1, 1'b0, fa, rnd_fld(), 0, 20'h12345, 1'b0);
    check("first_grant_port0", 32'(grant_log[0]), 32'd0);

    fb = '{s0: 4'd9, s1: 4'd3, d: 4'd1, we: 1'b0};
    run_txn(1'b0, 1'b1, rnd_fld(), fb, 0, 20'hABCDE, 1'b0);

    grant_log.delete();
    for (int k = 0; k < 4; k++)
      run_txn(1'b1, 1'b1, rnd_fld(), rnd_fld(), int'($urandom_range(0, 3)), 20'($urandom), 1'b0);
    for (int k = 0; k < 4; k++)
      check("contention_order", 32'(grant_log[k]), 32'(k % 2));

    run_txn(1'b1, 1'b0, rnd_fld(), rnd_fld(), 10, 20'($urandom), 1'b0);

    run_txn(1'b0, 1'b1, rnd_fld(), rnd_fld(), 0, 20'($urandom), 1'b1);
    grant_log.delete();
    run_txn(1'b1, 1'b1, rnd_fld(), rnd_fld(), 1, 20'($urandom), 1'b0);
    check("post_reset_grant_port0", 32'(grant_log[0]), 32'd0);

    for (int k = 0; k < 60; k++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      if ($urandom_range(0, 3) == 0) idle_cycle();
      run_txn(r0, r1, rnd_fld(), rnd_fld(), int'($urandom_range(0, 6)), 20'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sched.md
Name: regfile_sched

Overview:
- Scheduler that shares the 16-entry register file and the ALU between two requesters (port 0 and port 1).
- Each granted operation runs as one transaction:
  - read two source registers,
  - start the ALU,
  - wait for the result,
  - optionally write the result back to a destination register, then acknowledge the requester.
- Sits between the requesters and the register-file/ALU pair. It drives the register-file select, enable and write-data lines.

Parameters:
- N, 19: data MSB index; data width is N+1.
- M, 3: register-address MSB index; address width is M+1, giving 16 registers.

Ports:
- clk  in  1  system clock. All state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  transaction request from port 0 / port 1.
- src0_0, src1_0, dst_0  in  M+1 each  port-0 source A, source B and destination addresses.
- src0_1, src1_1, dst_1  in  M+1 each  the same three fields for port 1.
- we_0, we_1  in  1 each  1 = write the result back to dst; 0 = discard the result.
- ack0, ack1  out  1 each  one-cycle completion pulse to the granted port.
- busy  out  1  high whenever the state is not IDLE.
- rf_s0, rf_s1  out  M+1 each  register-file read selects.
- rf_rd0_en, rf_rd1_en  out  1 each  register-file read-port enables.
- rf_dest  out  M+1  register-file write address.
- rf_wr_en  out  1  register-file write enable.
- rf_wdata  out  N+1  register-file write data.
- alu_start  out  1  one-cycle pulse: operands on the register-file outputs are valid.
- alu_done  in  1  ALU result valid. Sampled in WAIT only.
- alu_result  in  N+1  ALU result, captured when alu_done is sampled high.
- err  out  1  one-cycle pulse on timeout. Exists only with SCHED_TIMEOUT_EN; otherwise tied 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE, last_grant = 1, so port 0 wins first;
  - all outputs 0, latched fields 0.
- Reset mid-transaction aborts immediately: no write, no ack.
- IDLE:
  - If any req is high, grant one port and latch its src0/src1/dst/we into internal registers; go to READ.
  - Arbitration is round-robin. When both req are high, grant the port other than last_grant; update last_grant on grant.
  - Fields are sampled only in the grant cycle. A req that drops before grant is ignored.
- READ (1 cycle):
  - rf_s0 = latched src0, rf_s1 = latched src1, rf_rd0_en = rf_rd1_en = 1.
  - Go to EXEC.
- EXEC (1 cycle):
  - Read enables low; rf_s0/rf_s1 hold their values.
  - alu_start = 1; go to WAIT.
- WAIT:
  - Hold until alu_done = 1, then latch alu_result into rf_wdata.
  - If the latched we = 1, go to WB; otherwise pulse ack for the granted port and go to IDLE.
  - alu_done asserted in any other state is ignored.
- WB (1 cycle):
  - rf_dest = latched dst, rf_wr_en = 1, rf_wdata stable.
  - Pulse ack for the granted port; go to IDLE.
- Latency:
  - Grant cycle T0, READ T1, EXEC T2 (alu_start).
  - Fastest completion has alu_done at T3, ack at T4, rf_wr_en at T4.
- rf_wr_en is never high in READ or EXEC, so a read and a write are never issued in the same cycle.
- Outputs:
  - ack0/ack1 are mutually exclusive, at most one pulse per transaction.
  - busy = (state != IDLE).
- A requester that holds req high after its ack re-enters arbitration in the next IDLE cycle.
  - IDLE always lasts at least one cycle between transactions.
  - Round-robin therefore alternates under continuous contention.
- Register hazard: a read of the register written by the previous transaction is safe, because its WB completes before the next READ.

Optional Feature:
- Macro SCHED_TIMEOUT_EN, with parameter TMO (default 255).
- With the macro defined:
  - an 8-bit counter clears on entry to WAIT and increments each WAIT cycle;
  - if it reaches TMO without alu_done, pulse err for 1 cycle and go to IDLE with no write and no ack;
  - last_grant is still updated;
  - alu_done in the same cycle as the timeout takes priority, and the transaction completes normally.
- Without the macro: WAIT is unbounded and err is constant 0.

Test Plan:
- Reset, then req0 with src0=2, src1=5, dst=7, we=1; alu_done at T3 with result 0x12345 -> rf_s0=2, rf_s1=5, rd_en high at T1; alu_start at T2; rf_wr_en=1, rf_dest=7, rf_wdata=0x12345 and ack0=1 at T4.
- req0 and req1 both held high for 4 transactions -> grants in order 0,1,0,1; ack pulses alternate; never both acks in one cycle.
- req1 with we=0, result 0xABCDE -> ack1 pulses the cycle after alu_done; rf_wr_en stays 0 for the whole transaction.
- alu_done held low for 10 WAIT cycles, then high -> busy high throughout; exactly one ack; latched fields unchanged despite req-field changes during WAIT.
- rst_n pulled low during WAIT -> all outputs 0 asynchronously; no write or ack; the next transaction after release grants port 0.
- With SCHED_TIMEOUT_EN and TMO=4, alu_done never asserted -> err pulses after 4 WAIT cycles; no ack; state returns to IDLE; a pending req1 is granted next.
